button_debounce_ctrl: RTL and testbench
=======================================

// Module: button_debounce_ctrl
// PURPOSE
//  Conditions one raw mechanical push-button input into clean, single-cycle events.
//  Stages: 2-FF synchronizer, then a debounce FSM with a stability counter, then a hold timer.
//  Sits between a board button pin (or the bouncing-button model in simulation) and the user logic.
//  Outputs: debounced level, press/release/long-press pulses, wrapping press counter.
// PARAMETERS
//  STABLE_CYCLES  4    consecutive agreeing synced samples to accept a level change (>=1)
//  LONG_CYCLES    100  cycles held after press_pulse before long_pulse fires (>=1)
//  CNT_W          16   width of stability and hold counters; must hold max(STABLE,LONG)
//  PCNT_W         8    width of press_count
// PORTS
//  clk          in   1       system clock, all logic on posedge
//  rst_n        in   1       synchronous reset, active-low
//  btn_raw      in   1       asynchronous, bouncing button level (1 = pressed)
//  btn_state    out  1       debounced level
//  press_pulse  out  1       1-cycle strobe on accepted press
//  release_pulse out 1       1-cycle strobe on accepted release
//  long_pulse   out  1       1-cycle strobe, at most once per press
//  press_count  out  PCNT_W  number of accepted presses, wraps modulo 2^PCNT_W
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//   - sync FFs=0, FSM=IDLE, all counters=0
//   - all outputs 0; no pulse in the cycle after reset
//   - any in-flight event is discarded
//  Synchronizer: btn_sync = btn_raw delayed 2 clocks. FSM uses only btn_sync.
//  FSM states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT; scnt = stability counter:
//   IDLE:        btn_sync=1 -> PRESS_WAIT, scnt<=1
//   PRESS_WAIT:  btn_sync=0 -> IDLE, no event
//                else scnt==STABLE_CYCLES -> PRESSED, press_pulse<=1, btn_state<=1,
//                press_count++, hold<=0
//                else scnt++
//   PRESSED:     btn_sync=0 -> RELEASE_WAIT, scnt<=1
//   RELEASE_WAIT: btn_sync=1 -> PRESSED, no new press_pulse, hold not cleared
//                else scnt==STABLE_CYCLES -> IDLE, release_pulse<=1, btn_state<=0
//                else scnt++
//  Latency: btn_raw first sampled 1 at edge k, then held
//   -> press_pulse high in the cycle after edge k+2+STABLE_CYCLES.
//   Release is symmetric.
//  Hold timer:
//   - increments every cycle in PRESSED or RELEASE_WAIT; saturates at LONG_CYCLES
//   - long_pulse<=1 on the edge where hold goes LONG_CYCLES-1 -> LONG_CYCLES
//     (LONG_CYCLES cycles after press_pulse)
//   - if that edge is also the accepting release edge, long_pulse and release_pulse both fire
//  Pulses are registered and last exactly 1 cycle; press_pulse and release_pulse never coincide.
//  press_count wraps all-ones -> 0 silently.
//  Any sync=0 sample in PRESS_WAIT (or sync=1 in RELEASE_WAIT) restarts stability from scratch.
//  Button held through reset: after rst_n returns high, treated as a fresh press
//   (same latency, counted from the first edge with rst_n=1).
// TESTING
//  T1 clean press, S=4:
//   btn_raw 0->1 before edge 10, held -> press_pulse only in cycle after edge 16;
//   btn_state=1 from then; press_count=1.
//  T2 press bounce:
//   1-cycle low glitch while in PRESS_WAIT -> no press_pulse;
//   press_pulse 2+S cycles after the last glitch sample.
//  T3 long press, L=100:
//   hold 150 cycles -> exactly one long_pulse, 100 cycles after press_pulse;
//   hold 80 cycles -> no long_pulse.
//  T4 release bounce:
//   1->0 with 3 bounces -> single release_pulse, btn_state 0;
//   bounce back to 1 inside RELEASE_WAIT -> PRESSED, no extra press_pulse, hold continues.
//  T5 reset mid-hold:
//   rst_n=0 one cycle while PRESSED -> all outputs 0 next cycle;
//   button still held -> press_pulse after edge r+2+S (r = first edge with rst_n=1).
//  T6 wrap + random:
//   256 clean presses -> press_count returns to 0;
//   10k-cycle random bouncing stimulus -> #press_pulse == #release_pulse (+/-1);
//   no two pulses closer than S+1 cycles.

Source files
------------

// File: rtl/button_debounce_ctrl_if.sv
// Signal bundle between a push-button source and the debounce controller.
// The source drives the raw level; the controller returns the clean level and event strobes.
interface button_debounce_ctrl_if #(
  parameter int PCNT_W = 8
);
  logic              btn_raw;
  logic              btn_state;
  logic              press_pulse;
  logic              release_pulse;
  logic              long_pulse;
  logic [PCNT_W-1:0] press_count;

  modport master (
    output btn_raw,
    input  btn_state,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse,
    input  press_count
  );

  modport slave (
    input  btn_raw,
    output btn_state,
    output press_pulse,
    output release_pulse,
    output long_pulse,
    output press_count
  );
endinterface

// File: rtl/button_debounce_ctrl.sv
// Push-button conditioner: 2-FF synchronizer, stability-counting debounce FSM and hold timer.
// Produces a clean level plus single-cycle press, release and long-press strobes.
module button_debounce_ctrl #(
  parameter int STABLE_CYCLES = 4,
  parameter int LONG_CYCLES   = 100,
  parameter int CNT_W         = 16,
  parameter int PCNT_W        = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  button_debounce_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_e;

  localparam logic [CNT_W-1:0]  STABLE_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]  LONG_MAX   = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [PCNT_W-1:0] PCNT_ONE   = PCNT_W'(1);

  state_e            state_q, state_d;
  logic              sync1_q, sync2_q;
  logic [CNT_W-1:0]  scnt_q, scnt_d;
  logic [CNT_W-1:0]  hold_q, hold_d;
  logic              btnState_q, btnState_d;
  logic              pressPulse_q, pressPulse_d;
  logic              releasePulse_q, releasePulse_d;
  logic              longPulse_q, longPulse_d;
  logic [PCNT_W-1:0] pressCount_q, pressCount_d;
  logic              btnSync;

  assign btnSync = sync2_q;

  always_comb begin
    state_d        = state_q;
    scnt_d         = scnt_q;
    hold_d         = hold_q;
    btnState_d     = btnState_q;
    pressPulse_d   = 1'b0;
    releasePulse_d = 1'b0;
    longPulse_d    = 1'b0;
    pressCount_d   = pressCount_q;

    // Hold timer runs while the button is considered down, including release bounce.
    if ((state_q == PRESSED || state_q == RELEASE_WAIT) && hold_q != LONG_MAX) begin
      hold_d = hold_q + CNT_ONE;
      if (hold_q == LONG_MAX - CNT_ONE) begin
        longPulse_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (btnSync) begin
          state_d = PRESS_WAIT;
          scnt_d  = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!btnSync) begin
          state_d = IDLE;
        end else if (scnt_q == STABLE_MAX) begin
          state_d      = PRESSED;
          pressPulse_d = 1'b1;
          btnState_d   = 1'b1;
          pressCount_d = pressCount_q + PCNT_ONE;
          hold_d       = '0;
        end else begin
          scnt_d = scnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!btnSync) begin
          state_d = RELEASE_WAIT;
          scnt_d  = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (btnSync) begin
          state_d = PRESSED;
        end else if (scnt_q == STABLE_MAX) begin
          state_d        = IDLE;
          releasePulse_d = 1'b1;
          btnState_d     = 1'b0;
        end else begin
          scnt_d = scnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      state_q        <= IDLE;
      scnt_q         <= '0;
      hold_q         <= '0;
      btnState_q     <= 1'b0;
      pressPulse_q   <= 1'b0;
      releasePulse_q <= 1'b0;
      longPulse_q    <= 1'b0;
      pressCount_q   <= '0;
    end else begin
      sync1_q        <= bus.btn_raw;
      sync2_q        <= sync1_q;
      state_q        <= state_d;
      scnt_q         <= scnt_d;
      hold_q         <= hold_d;
      btnState_q     <= btnState_d;
      pressPulse_q   <= pressPulse_d;
      releasePulse_q <= releasePulse_d;
      longPulse_q    <= longPulse_d;
      pressCount_q   <= pressCount_d;
    end
  end

  assign bus.btn_state     = btnState_q;
  assign bus.press_pulse   = pressPulse_q;
  assign bus.release_pulse = releasePulse_q;
  assign bus.long_pulse    = longPulse_q;
  assign bus.press_count   = pressCount_q;

endmodule

// File: tb/tb_button_debounce_ctrl.sv
// Self-checking bench for button_debounce_ctrl: exact-latency sequences, a table of
// bounce/hold vectors, reset mid-hold, press counter wrap and a random bounce run.
module tb_button_debounce_ctrl;
  localparam int S  = 4;
  localparam int L  = 100;
  localparam int PW = 8;

  typedef struct {
    logic raw;
    int   cycles;
    logic expState;
    int   expPress;
    int   expRelease;
    int   expLong;
    int   expLongRel;
    int   expCount;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  button_debounce_ctrl_if #(.PCNT_W(PW)) bus ();

  button_debounce_ctrl #(
    .STABLE_CYCLES(S),
    .LONG_CYCLES  (L),
    .CNT_W        (16),
    .PCNT_W       (PW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int pressSeen = 0;
  int releaseSeen = 0;
  int longSeen = 0;
  int longRelSeen = 0;
  int overlapSeen = 0;
  int spacingViol = 0;
  int lastPulse = -1000;
  vec_t vecs[16];

  // One clock edge, then observe the registered outputs away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cycle++;
    if (bus.press_pulse || bus.release_pulse) begin
      if (cycle - lastPulse < S + 1) spacingViol++;
      lastPulse = cycle;
    end
    if (bus.press_pulse) pressSeen++;
    if (bus.release_pulse) releaseSeen++;
    if (bus.long_pulse) longSeen++;
    if (bus.long_pulse && bus.release_pulse) longRelSeen++;
    if (bus.press_pulse && bus.release_pulse) overlapSeen++;
  endtask

  task automatic applyStimulus(input logic raw, input int n);
    bus.btn_raw = raw;
    repeat (n) step();
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " btn_state"}, int'(bus.btn_state), 0);
    checkOutput({tag, " press_pulse"}, int'(bus.press_pulse), 0);
    checkOutput({tag, " release_pulse"}, int'(bus.release_pulse), 0);
    checkOutput({tag, " long_pulse"}, int'(bus.long_pulse), 0);
    checkOutput({tag, " press_count"}, int'(bus.press_count), 0);
  endtask

  initial begin
    int early;
    int base;
    int bP, bR, bL, bLR;
    int total;
    int len;
    logic raw;

    // Hand-computed vectors, starting from IDLE with press_count 1 and raw low.
    vecs[0]  = '{1'b1,   3, 1'b0, 0, 0, 0, 0, 1};
    vecs[1]  = '{1'b0,   1, 1'b0, 0, 0, 0, 0, 1};
    vecs[2]  = '{1'b1,  10, 1'b1, 1, 0, 0, 0, 2};
    vecs[3]  = '{1'b0,   2, 1'b1, 0, 0, 0, 0, 2};
    vecs[4]  = '{1'b1,   1, 1'b1, 0, 0, 0, 0, 2};
    vecs[5]  = '{1'b0,   1, 1'b1, 0, 0, 0, 0, 2};
    vecs[6]  = '{1'b1,   1, 1'b1, 0, 0, 0, 0, 2};
    vecs[7]  = '{1'b0,  20, 1'b0, 0, 1, 0, 0, 2};
    vecs[8]  = '{1'b1,  50, 1'b1, 1, 0, 0, 0, 3};
    vecs[9]  = '{1'b0,   3, 1'b1, 0, 0, 0, 0, 3};
    vecs[10] = '{1'b1,  60, 1'b1, 0, 0, 1, 0, 3};
    vecs[11] = '{1'b0,  10, 1'b0, 0, 1, 0, 0, 3};
    vecs[12] = '{1'b1,  80, 1'b1, 1, 0, 0, 0, 4};
    vecs[13] = '{1'b0,  10, 1'b0, 0, 1, 0, 0, 4};
    vecs[14] = '{1'b1, 100, 1'b1, 1, 0, 0, 0, 5};
    vecs[15] = '{1'b0,  10, 1'b0, 0, 1, 1, 1, 5};

    bus.btn_raw = 1'b0;
    rst_n = 1'b0;
    applyStimulus(1'b0, 3);
    checkAllZero("reset");
    rst_n = 1'b1;
    applyStimulus(1'b0, 2);

    // Clean press: accepted on the seventh edge after raw rises.
    bus.btn_raw = 1'b1;
    early = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.press_pulse) early++;
    end
    checkOutput("T1 early press", early, 0);
    step();
    checkOutput("T1 press_pulse", int'(bus.press_pulse), 1);
    checkOutput("T1 btn_state", int'(bus.btn_state), 1);
    checkOutput("T1 press_count", int'(bus.press_count), 1);
    step();
    checkOutput("T1 press_pulse width", int'(bus.press_pulse), 0);

    // Long press: strobe exactly L cycles after press_pulse, never repeated.
    base = longSeen;
    repeat (L - 2) step();
    checkOutput("T3 early long", longSeen - base, 0);
    step();
    checkOutput("T3 long_pulse", int'(bus.long_pulse), 1);
    base = longSeen;
    applyStimulus(1'b1, 42);
    checkOutput("T3 repeated long", longSeen - base, 0);

    // Clean release with the same latency.
    bus.btn_raw = 1'b0;
    base = releaseSeen;
    repeat (6) step();
    checkOutput("T1 early release", releaseSeen - base, 0);
    step();
    checkOutput("T1 release_pulse", int'(bus.release_pulse), 1);
    checkOutput("T1 release btn_state", int'(bus.btn_state), 0);
    step();
    checkOutput("T1 release width", int'(bus.release_pulse), 0);

    for (int i = 0; i < 16; i++) begin
      bP = pressSeen; bR = releaseSeen; bL = longSeen; bLR = longRelSeen;
      applyStimulus(vecs[i].raw, vecs[i].cycles);
      checkOutput($sformatf("vec%0d press", i), pressSeen - bP, vecs[i].expPress);
      checkOutput($sformatf("vec%0d release", i), releaseSeen - bR, vecs[i].expRelease);
      checkOutput($sformatf("vec%0d long", i), longSeen - bL, vecs[i].expLong);
      checkOutput($sformatf("vec%0d long+release", i), longRelSeen - bLR, vecs[i].expLongRel);
      checkOutput($sformatf("vec%0d btn_state", i), int'(bus.btn_state), int'(vecs[i].expState));
      checkOutput($sformatf("vec%0d press_count", i), int'(bus.press_count), vecs[i].expCount);
    end

    // Reset while held: everything clears, then the held button is a fresh press.
    applyStimulus(1'b1, 20);
    checkOutput("T5 pre-reset count", int'(bus.press_count), 6);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checkAllZero("T5 after reset");
    base = longSeen;
    early = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.press_pulse) early++;
    end
    checkOutput("T5 early press", early, 0);
    step();
    checkOutput("T5 press_pulse", int'(bus.press_pulse), 1);
    checkOutput("T5 press_count", int'(bus.press_count), 1);
    applyStimulus(1'b0, 10);
    checkOutput("T5 discarded long", longSeen - base, 0);
    checkOutput("T5 released", int'(bus.btn_state), 0);

    // 255 more clean presses take the counter from 1 around to 0.
    base = pressSeen;
    repeat (255) begin
      applyStimulus(1'b1, 8);
      applyStimulus(1'b0, 8);
    end
    checkOutput("T6 wrap presses", pressSeen - base, 255);
    checkOutput("T6 wrap count", int'(bus.press_count), 0);

    // Random bouncing, then settle low so every press has its release.
    bP = pressSeen; bR = releaseSeen; bL = longSeen;
    total = 0;
    raw = 1'b0;
    while (total < 10000) begin
      raw = ~raw;
      len = $urandom_range(1, 12);
      applyStimulus(raw, len);
      total += len;
    end
    applyStimulus(1'b0, 20);
    checkOutput("T6 random activity", int'((pressSeen - bP) > 0), 1);
    checkOutput("T6 press vs release", pressSeen - bP, releaseSeen - bR);
    checkOutput("T6 random count", int'(bus.press_count), (pressSeen - bP) % 256);
    checkOutput("T6 random btn_state", int'(bus.btn_state), 0);
    checkOutput("T6 long per press", int'((longSeen - bL) <= (pressSeen - bP)), 1);
    checkOutput("pulse spacing", spacingViol, 0);
    checkOutput("press/release overlap", overlapSeen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
